// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle for the post-subtraction normalizer.
// The master side issues operands, the slave side returns results.
interface fp_normalizer_if;
  logic        start;
  logic [31:0] diffIn;
  logic        carryIn;
  logic [7:0]  expIn;
  logic [31:0] mantOut;
  logic [7:0]  expOut;
  logic        signOut;
  logic        zeroFlag;
  logic        underflow;
  logic        busy;
  logic        done;

  modport master (
    output start, diffIn, carryIn, expIn,
    input  mantOut, expOut, signOut,
    input  zeroFlag, underflow, busy, done
  );

  modport slave (
    input  start, diffIn, carryIn, expIn,
    output mantOut, expOut, signOut,
    output zeroFlag, underflow, busy, done
  );
endinterface

// File: rtl/fp_normalizer.sv
// Sequential normalizer: recovers sign/magnitude of a subtraction
// result, then shifts left one bit per cycle until the MSB is set.
module fp_normalizer (
  input logic             clk,
  input logic             reset,
  fp_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic        unf_q, unf_d;

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state logic: capture, prioritized shift step, completion.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mag_d   = bus.carryIn ? bus.diffIn
                                : (~bus.diffIn + 32'd1);
          exp_d   = bus.expIn;
          sign_d  = ~bus.carryIn;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (mag_q == 32'd0) begin
          zero_d  = 1'b1;
          exp_d   = 8'd0;
          sign_d  = 1'b0;
          state_d = DONE;
        end else if (mag_q[31]) begin
          state_d = DONE;
        end else if (exp_q == 8'd0) begin
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mantOut   = mag_q;
  assign bus.expOut    = exp_q;
  assign bus.signOut   = sign_q;
  assign bus.zeroFlag  = zero_q;
  assign bus.underflow = unf_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule
